// File: rtl/iigs_sound_glu.sv
// iigs_sound_glu: decodes the IIgs sound registers into sound-RAM / DOC accesses.
// Host ops are queued at the strobe and executed on the first clk outside the DOC window.
module iigs_sound_glu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ph0_en_i,
    input  logic        select_i,
    input  logic        wr_i,
    input  logic [1:0]  host_addr_i,
    input  logic [7:0]  host_data_in_i,
    input  logic [7:0]  sound_data_in_i,
    output logic        ram_access_o,
    output logic [7:0]  host_data_out_o,
    output logic [15:0] sound_addr_o,
    output logic [7:0]  sound_data_out_o,
    output logic        ram_wr_o,
    output logic        doc_wr_o,
    output logic        doc_enable_o
);
    logic [1:0]  win_q, win_d;
    logic        pend_q, pend_d;
    logic        op_wr_q, op_wr_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  latch_q, latch_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        stb, exec;

    assign stb  = select_i & ph0_en_i;
    assign exec = pend_q & ~doc_enable_o;

    assign doc_enable_o     = win_q != 2'd0;
    assign ram_access_o     = ctrl_q[6];
    assign sound_addr_o     = addr_q;
    assign sound_data_out_o = wdata_q;
    assign ram_wr_o         = exec & op_wr_q & ctrl_q[6];
    assign doc_wr_o         = exec & op_wr_q & ~ctrl_q[6];

    // busy is simply "an op is queued"; it overlays control bit 7 on reads
    always_comb
        host_data_out_o = host_addr_i == 2'd0 ? {pend_q, ctrl_q[6:0]} :
                          host_addr_i == 2'd1 ? latch_q :
                          host_addr_i == 2'd2 ? addr_q[7:0] : addr_q[15:8];

    always_comb begin
        win_d   = ph0_en_i ? 2'd2 : (doc_enable_o ? win_q - 2'd1 : 2'd0);
        pend_d  = pend_q;
        op_wr_d = op_wr_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        latch_d = latch_q;
        wdata_d = wdata_q;
        if (exec) begin
            pend_d = 1'b0;
            if (!op_wr_q)
                latch_d = sound_data_in_i;
            if (ctrl_q[5])
                addr_d = addr_q + 16'd1;
        end
        if (stb && wr_i && host_addr_i == 2'd0)
            ctrl_d = host_data_in_i & 8'h6F;
        if (stb && wr_i && host_addr_i == 2'd1)
            wdata_d = host_data_in_i;
        if (stb && wr_i && host_addr_i == 2'd2)
            addr_d[7:0] = host_data_in_i;
        if (stb && wr_i && host_addr_i == 2'd3)
            addr_d[15:8] = host_data_in_i;
        if (stb && host_addr_i == 2'd1) begin
            pend_d  = 1'b1;
            op_wr_d = wr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q   <= 2'd0;
            pend_q  <= 1'b0;
            op_wr_q <= 1'b0;
            ctrl_q  <= 8'h00;
            addr_q  <= 16'h0000;
            latch_q <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            win_q   <= win_d;
            pend_q  <= pend_d;
            op_wr_q <= op_wr_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            latch_q <= latch_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_iigs_sound_glu.sv
// tb_iigs_sound_glu: directed bus cycles; expected RAM/DOC strobes go through a
// scoreboard queue that a negedge monitor drains as the DUT emits them.
module tb_iigs_sound_glu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ph0_en = 1'b0, select = 1'b0, wr = 1'b0;
    logic [1:0]  host_addr = 2'd0;
    logic [7:0]  host_data_in = 8'h00;
    logic [7:0]  sound_data_in;
    logic        ram_access, ram_wr, doc_wr, doc_enable;
    logic [7:0]  host_data_out, sound_data_out;
    logic [15:0] sound_addr;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  rd, st_mid, st_after;
    logic [13:0] en_pat, str_pat;

    always #5 clk = ~clk;

    // sound RAM model; DOC side returns a fixed marker
    always_comb
        sound_data_in = !ram_access ? 8'hD0 :
                        sound_addr == 16'h0010 ? 8'h11 :
                        sound_addr == 16'h0011 ? 8'h22 : 8'h5A;

    iigs_sound_glu dut (
        .clk_i(clk), .rst_ni(rst_n), .ph0_en_i(ph0_en), .select_i(select), .wr_i(wr),
        .host_addr_i(host_addr), .host_data_in_i(host_data_in), .sound_data_in_i(sound_data_in),
        .ram_access_o(ram_access), .host_data_out_o(host_data_out), .sound_addr_o(sound_addr),
        .sound_data_out_o(sound_data_out), .ram_wr_o(ram_wr), .doc_wr_o(doc_wr),
        .doc_enable_o(doc_enable)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one 14-clk CPU bus cycle; bit i of the patterns is the sample during P+i
    task automatic bus(input logic s, input logic w, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        select = s; wr = w; host_addr = a; host_data_in = d; ph0_en = 1'b1;
        #1;
        rd = host_data_out;
        en_pat[0] = doc_enable;
        str_pat[0] = ram_wr | doc_wr;
        for (int i = 1; i < 14; i++) begin
            @(negedge clk);
            if (i == 1) begin
                ph0_en = 1'b0;
                select = 1'b0;
            end
            if (i == 2) host_addr = 2'd0;
            #1;
            en_pat[i] = doc_enable;
            str_pat[i] = ram_wr | doc_wr;
            if (i == 2) st_mid = host_data_out;
            if (i == 5) st_after = host_data_out;
        end
    endtask

    always @(negedge clk) begin
        if (ram_wr | doc_wr) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_strobe: observed ram_wr=%b doc_wr=%b expected none", ram_wr, doc_wr);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {14'd0, ram_wr, doc_wr}, {14'd0, e.kind});
                check("strobe_addr", sound_addr, e.addr);
                check("strobe_data", {8'd0, sound_data_out}, {8'd0, e.data});
                check("strobe_outside_window", {15'd0, doc_enable}, 16'd0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_status", {8'd0, host_data_out}, 16'h0000);
        check("reset_addr", sound_addr, 16'h0000);
        check("reset_wdata", {8'd0, sound_data_out}, 16'h0000);
        check("reset_flags", {12'd0, ram_access, ram_wr, doc_wr, doc_enable}, 16'h0000);
        rst_n = 1'b1;

        // RAM write with auto-increment
        bus(1, 1, 2'd0, 8'h60);
        check("ram_access", {15'd0, ram_access}, 16'h0001);
        bus(1, 1, 2'd2, 8'h34);
        bus(1, 1, 2'd3, 8'h12);
        exp_q.push_back('{2'b10, 16'h1234, 8'hAB});
        bus(1, 1, 2'd1, 8'hAB);
        check("ram_wr_timing", {2'd0, str_pat}, 16'h0008);
        check("window_on_write", {2'd0, en_pat}, 16'h0006);
        bus(1, 0, 2'd2, 8'h00);
        check("inc_addr_lo", {8'd0, rd}, 16'h0035);
        bus(1, 0, 2'd3, 8'h00);
        check("inc_addr_hi", {8'd0, rd}, 16'h0012);

        // DOC write without increment
        bus(1, 1, 2'd0, 8'h00);
        bus(1, 1, 2'd2, 8'hE1);
        exp_q.push_back('{2'b01, 16'h12E1, 8'h3C});
        bus(1, 1, 2'd1, 8'h3C);
        check("doc_wr_timing", {2'd0, str_pat}, 16'h0008);
        bus(1, 0, 2'd2, 8'h00);
        check("doc_addr_kept", {8'd0, rd}, 16'h00E1);

        // bits 7 and 4 of control are not writable
        bus(1, 1, 2'd0, 8'hFF);
        bus(1, 0, 2'd0, 8'h00);
        check("ctrl_mask", {8'd0, rd}, 16'h006F);

        // read pipeline
        bus(1, 1, 2'd0, 8'h60);
        bus(1, 1, 2'd2, 8'h10);
        bus(1, 1, 2'd3, 8'h00);
        bus(1, 0, 2'd1, 8'h00);
        check("read1_stale", {8'd0, rd}, 16'h0000);
        check("busy_during_op", {8'd0, st_mid}, 16'h00E0);
        check("status_after_op", {8'd0, st_after}, 16'h0060);
        check("read_no_strobe", {2'd0, str_pat}, 16'h0000);
        bus(1, 0, 2'd1, 8'h00);
        check("read2", {8'd0, rd}, 16'h0011);
        bus(1, 0, 2'd1, 8'h00);
        check("read3", {8'd0, rd}, 16'h0022);
        check("read_addr_inc", sound_addr, 16'h0013);

        // address wrap
        bus(1, 1, 2'd2, 8'hFF);
        bus(1, 1, 2'd3, 8'hFF);
        exp_q.push_back('{2'b10, 16'hFFFF, 8'h77});
        bus(1, 1, 2'd1, 8'h77);
        bus(1, 0, 2'd2, 8'h00);
        check("wrap_lo", {8'd0, rd}, 16'h0000);
        bus(1, 0, 2'd3, 8'h00);
        check("wrap_hi", {8'd0, rd}, 16'h0000);

        // window with select low: no host effect, no strobes
        for (int k = 0; k < 2; k++) begin
            bus(0, 1, 2'd1, 8'h55);
            check("window_only", {2'd0, en_pat}, 16'h0006);
            check("window_no_strobe", {2'd0, str_pat}, 16'h0000);
        end

        // reset in the middle of a queued RAM write
        @(negedge clk);
        select = 1'b1; wr = 1'b1; host_addr = 2'd1; host_data_in = 8'h99; ph0_en = 1'b1;
        @(negedge clk);
        select = 1'b0; ph0_en = 1'b0; host_addr = 2'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_status", {8'd0, host_data_out}, 16'h0000);
        check("rst_mid_flags", {12'd0, ram_access, ram_wr, doc_wr, doc_enable}, 16'h0000);
        check("rst_mid_addr", sound_addr, 16'h0000);
        check("rst_mid_wdata", {8'd0, sound_data_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        bus(1, 0, 2'd0, 8'h00);
        check("post_reset_status", {8'd0, rd}, 16'h0000);
        check("post_reset_no_strobe", {2'd0, str_pat}, 16'h0000);

        check("scoreboard_drained", exp_q.size(), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
